amm_arbiter_2to1: RTL and testbench

- Two-master, one-slave Avalon-MM arbiter.
- Lets two bridge/master instances (e.g. two AXI4-Lite-to-Avalon bridges, or a bridge plus a DMA) share one Avalon-MM slave.
- Grants one complete single-beat transaction at a time, with round-robin or fixed priority, and guards the slave with a waitrequest watchdog.
- Sits between the masters' Avalon-MM ports and the slave's fabric port.

---
 rtl/amm_arbiter_2to1_if.sv | 23 ++
 rtl/amm_arbiter_2to1.sv | 114 +++++++++++
 tb/tb_amm_arbiter_2to1.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/amm_arbiter_2to1_if.sv
// Single-beat Avalon-MM link (no readdatavalid): one master side, one slave side.
interface amm_arbiter_2to1_if #(
    parameter int P_ASIZE  = 32,
    parameter int P_DBYTES = 4
);
    logic [P_ASIZE-1:0]    address;
    logic [P_DBYTES*8-1:0] writedata;
    logic [P_DBYTES-1:0]   byteenable;
    logic                  write;
    logic                  read;
    logic [P_DBYTES*8-1:0] readdata;
    logic                  waitrequest;

    modport master (
        output address, writedata, byteenable, write, read,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, writedata, byteenable, write, read,
        output readdata, waitrequest
    );
endinterface

// File: rtl/amm_arbiter_2to1.sv
// Two-master, one-slave Avalon-MM arbiter: one single-beat transaction per grant,
// round-robin or fixed priority, with a waitrequest watchdog that forces completion.
module amm_arbiter_2to1 #(
    parameter int P_ASIZE   = 32,
    parameter int P_DBYTES  = 4,
    parameter bit P_RR      = 1'b1,
    parameter int P_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    amm_arbiter_2to1_if.slave  m0,
    amm_arbiter_2to1_if.slave  m1,
    amm_arbiter_2to1_if.master s,
    output logic               timeout_err
);
    localparam int WD_W = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(P_TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_G0   = 2'd1;
    localparam logic [1:0] S_G1   = 2'd2;
    localparam logic [1:0] S_REL  = 2'd3;

    logic [1:0]      state, state_nxt;
    logic            last, last_nxt;
    logic [WD_W-1:0] wdog, wdog_nxt;
    logic            req0, req1, granted, sel1, req_g, expire;

    assign req0    = m0.read | m0.write;
    assign req1    = m1.read | m1.write;
    assign granted = (state == S_G0) || (state == S_G1);
    assign sel1    = (state == S_G1);
    assign req_g   = sel1 ? req1 : req0;

    // Expiry only counts while the granted master still holds its request.
    assign expire = (P_TIMEOUT != 0) && granted && req_g && s.waitrequest && (wdog == WD_MAX);

    assign timeout_err = expire;

    always_comb begin
        s.address    = '0;
        s.writedata  = '0;
        s.byteenable = '0;
        s.read       = 1'b0;
        s.write      = 1'b0;
        if (state == S_G0) begin
            s.address    = m0.address;
            s.writedata  = m0.writedata;
            s.byteenable = m0.byteenable;
            s.read       = m0.read;
            s.write      = m0.write;
        end else if (state == S_G1) begin
            s.address    = m1.address;
            s.writedata  = m1.writedata;
            s.byteenable = m1.byteenable;
            s.read       = m1.read;
            s.write      = m1.write;
        end
    end

    always_comb begin
        m0.waitrequest = 1'b1;
        m0.readdata    = '0;
        m1.waitrequest = 1'b1;
        m1.readdata    = '0;
        if (state == S_G0) begin
            m0.waitrequest = s.waitrequest & ~expire;
            m0.readdata    = expire ? '0 : s.readdata;
        end else if (state == S_G1) begin
            m1.waitrequest = s.waitrequest & ~expire;
            m1.readdata    = expire ? '0 : s.readdata;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        wdog_nxt  = '0;
        case (state)
            S_IDLE: begin
                if (req0 && req1) begin
                    state_nxt = (P_RR && !last) ? S_G1 : S_G0;
                end else if (req0) begin
                    state_nxt = S_G0;
                end else if (req1) begin
                    state_nxt = S_G1;
                end
            end
            S_G0, S_G1: begin
                if (!req_g) begin
                    state_nxt = S_IDLE;
                end else if (!s.waitrequest || expire) begin
                    state_nxt = S_REL;
                    last_nxt  = sel1;
                end else if (P_TIMEOUT != 0) begin
                    wdog_nxt = wdog + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            last  <= 1'b1;
            wdog  <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            wdog  <= wdog_nxt;
        end
    end
endmodule

// File: tb/tb_amm_arbiter_2to1.sv
// Bench for amm_arbiter_2to1: a round-robin/watchdog instance and a fixed-priority,
// watchdog-off instance share stimulus and are compared cycle by cycle to a model.
module tb_amm_arbiter_2to1;
    localparam int AW    = 32;
    localparam int DB    = 4;
    localparam int TMO_A = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        rd;
        logic        wr;
    } cmd_t;

    typedef struct packed {
        cmd_t        s;
        logic [31:0] rdata0;
        logic [31:0] rdata1;
        logic        wait0;
        logic        wait1;
        logic        terr;
    } out_t;

    typedef struct {
        int owner;   // -1 nobody, else master index holding the slave
        bit bubble;  // release cycle after a completion
        int last;    // master that completed most recently
        int stall;   // consecutive stalled cycles of the current grant
    } mst_t;

    logic        clk = 1'b0;
    logic        reset_n;
    cmd_t        mcmd [2];
    logic        s_wait;
    logic [31:0] s_rdata;
    logic        terr_a, terr_b;
    out_t        act_a, act_b, obs_a, obs_b;
    mst_t        st_a, st_b;
    logic        done [2];
    int          comp_a, comp_b;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    amm_arbiter_2to1_if #(.P_ASIZE(AW), .P_DBYTES(DB)) a_m0 ();
    amm_arbiter_2to1_if #(.P_ASIZE(AW), .P_DBYTES(DB)) a_m1 ();
    amm_arbiter_2to1_if #(.P_ASIZE(AW), .P_DBYTES(DB)) a_s ();
    amm_arbiter_2to1_if #(.P_ASIZE(AW), .P_DBYTES(DB)) b_m0 ();
    amm_arbiter_2to1_if #(.P_ASIZE(AW), .P_DBYTES(DB)) b_m1 ();
    amm_arbiter_2to1_if #(.P_ASIZE(AW), .P_DBYTES(DB)) b_s ();

    assign a_m0.address = mcmd[0].addr;  assign b_m0.address = mcmd[0].addr;
    assign a_m0.writedata = mcmd[0].wdata; assign b_m0.writedata = mcmd[0].wdata;
    assign a_m0.byteenable = mcmd[0].be;  assign b_m0.byteenable = mcmd[0].be;
    assign a_m0.read = mcmd[0].rd;        assign b_m0.read = mcmd[0].rd;
    assign a_m0.write = mcmd[0].wr;       assign b_m0.write = mcmd[0].wr;
    assign a_m1.address = mcmd[1].addr;  assign b_m1.address = mcmd[1].addr;
    assign a_m1.writedata = mcmd[1].wdata; assign b_m1.writedata = mcmd[1].wdata;
    assign a_m1.byteenable = mcmd[1].be;  assign b_m1.byteenable = mcmd[1].be;
    assign a_m1.read = mcmd[1].rd;        assign b_m1.read = mcmd[1].rd;
    assign a_m1.write = mcmd[1].wr;       assign b_m1.write = mcmd[1].wr;
    assign a_s.waitrequest = s_wait;      assign b_s.waitrequest = s_wait;
    assign a_s.readdata = s_rdata;        assign b_s.readdata = s_rdata;

    assign act_a = {a_s.address, a_s.writedata, a_s.byteenable, a_s.read, a_s.write,
                    a_m0.readdata, a_m1.readdata, a_m0.waitrequest, a_m1.waitrequest, terr_a};
    assign act_b = {b_s.address, b_s.writedata, b_s.byteenable, b_s.read, b_s.write,
                    b_m0.readdata, b_m1.readdata, b_m0.waitrequest, b_m1.waitrequest, terr_b};

    amm_arbiter_2to1 #(.P_ASIZE(AW), .P_DBYTES(DB), .P_RR(1'b1), .P_TIMEOUT(TMO_A)) dut_a (
        .clk(clk), .reset_n(reset_n), .m0(a_m0), .m1(a_m1), .s(a_s), .timeout_err(terr_a));
    amm_arbiter_2to1 #(.P_ASIZE(AW), .P_DBYTES(DB), .P_RR(1'b0), .P_TIMEOUT(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .m0(b_m0), .m1(b_m1), .s(b_s), .timeout_err(terr_b));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit reqof(input cmd_t c);
        return c.rd | c.wr;
    endfunction

    function automatic mst_t rst_state();
        mst_t r;
        r.owner = -1; r.bubble = 1'b0; r.last = 1; r.stall = 0;
        return r;
    endfunction

    function automatic out_t model_out(input mst_t st, input cmd_t c0, input cmd_t c1,
                                       input logic sw, input logic [31:0] sr, input int tmo);
        out_t o;
        cmd_t g;
        bit   forced;
        o = '0;
        o.wait0 = 1'b1;
        o.wait1 = 1'b1;
        if (st.owner >= 0) begin
            g = (st.owner == 1) ? c1 : c0;
            o.s = g;
            forced = reqof(g) && sw && (tmo > 0) && (st.stall == tmo);
            o.terr = forced;
            if (st.owner == 0) begin
                o.wait0 = sw && !forced;
                o.rdata0 = forced ? 32'h0 : sr;
            end else begin
                o.wait1 = sw && !forced;
                o.rdata1 = forced ? 32'h0 : sr;
            end
        end
        return o;
    endfunction

    function automatic mst_t model_next(input mst_t st, input cmd_t c0, input cmd_t c1,
                                        input logic sw, input bit rr, input int tmo);
        mst_t n;
        cmd_t g;
        n = st;
        if (st.bubble) begin
            n.bubble = 1'b0;
            n.stall = 0;
        end else if (st.owner < 0) begin
            if (reqof(c0) && reqof(c1)) n.owner = rr ? 1 - st.last : 0;
            else if (reqof(c0)) n.owner = 0;
            else if (reqof(c1)) n.owner = 1;
            n.stall = 0;
        end else begin
            g = (st.owner == 1) ? c1 : c0;
            if (!reqof(g)) begin
                n.owner = -1;
                n.stall = 0;
            end else if (!sw || ((tmo > 0) && (st.stall == tmo))) begin
                n.last = st.owner;
                n.owner = -1;
                n.bubble = 1'b1;
                n.stall = 0;
            end else begin
                n.stall = st.stall + 1;
            end
        end
        return n;
    endfunction

    task automatic cmp_out(input string dn, input out_t act, input out_t exp);
        chk({dn, "_s_address"}, act.s.addr, exp.s.addr);
        chk({dn, "_s_writedata"}, act.s.wdata, exp.s.wdata);
        chk({dn, "_s_byteenable"}, act.s.be, exp.s.be);
        chk({dn, "_s_rd_wr"}, {act.s.rd, act.s.wr}, {exp.s.rd, exp.s.wr});
        chk({dn, "_m0_readdata"}, act.rdata0, exp.rdata0);
        chk({dn, "_m1_readdata"}, act.rdata1, exp.rdata1);
        chk({dn, "_waitrequests"}, {act.wait0, act.wait1}, {exp.wait0, exp.wait1});
        chk({dn, "_timeout_err"}, act.terr, exp.terr);
    endtask

    function automatic int completer(input out_t act);
        if (reqof(mcmd[0]) && !act.wait0) return 0;
        if (reqof(mcmd[1]) && !act.wait1) return 1;
        return -1;
    endfunction

    // Called on a falling edge with inputs already applied; returns on the next falling edge.
    task automatic step();
        out_t ea, eb;
        #1;
        ea = model_out(st_a, mcmd[0], mcmd[1], s_wait, s_rdata, TMO_A);
        eb = model_out(st_b, mcmd[0], mcmd[1], s_wait, s_rdata, 0);
        cmp_out("A", act_a, ea);
        cmp_out("B", act_b, eb);
        obs_a = act_a;
        obs_b = act_b;
        if (reqof(mcmd[0]) && !ea.wait0) done[0] = 1'b1;
        if (reqof(mcmd[1]) && !ea.wait1) done[1] = 1'b1;
        comp_a = completer(act_a);
        comp_b = completer(act_b);
        @(posedge clk);
        if (reset_n) begin
            st_a = model_next(st_a, mcmd[0], mcmd[1], s_wait, 1'b1, TMO_A);
            st_b = model_next(st_b, mcmd[0], mcmd[1], s_wait, 1'b0, 0);
        end else begin
            st_a = rst_state();
            st_b = rst_state();
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic new_cmd(input int i, input int pct);
        cmd_t c;
        int   k;
        c = '0;
        if (int'($urandom_range(99)) < pct) begin
            k = int'($urandom_range(15));
            c.rd = (k < 7) || (k == 15);
            c.wr = (k >= 7);
            c.addr = $urandom;
            c.wdata = $urandom;
            c.be = 4'($urandom);
        end
        mcmd[i] = c;
        done[i] = 1'b0;
    endtask

    task automatic drive_masters(input int p0, input int p1, input int wpct);
        if (done[0] || !reqof(mcmd[0])) new_cmd(0, p0);
        if (done[1] || !reqof(mcmd[1])) new_cmd(1, p1);
        s_wait = int'($urandom_range(99)) < wpct;
        s_rdata = $urandom;
    endtask

    task automatic idle(input int n);
        mcmd[0] = '0; mcmd[1] = '0;
        done[0] = 1'b0; done[1] = 1'b0;
        s_wait = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_done(input int i, input int lim, input string tag);
        int k;
        k = 0;
        while (!done[i] && k < lim) begin
            step();
            k++;
        end
        chk(tag, done[i], 1'b1);
    endtask

    initial begin
        int   wr_cnt, gcnt, prev_a, last0_a, last0_b, m1_b;
        cmd_t wr_seen;

        reset_n = 1'b0;
        mcmd[0] = '0; mcmd[1] = '0;
        done[0] = 1'b0; done[1] = 1'b0;
        s_wait = 1'b0;
        s_rdata = 32'hDEADBEEF;
        st_a = rst_state();
        st_b = rst_state();
        obs_a = '0;
        obs_b = '0;
        @(negedge clk);

        // Reset held with a pending read, then released.
        mcmd[0] = '{addr: 32'h40, wdata: 32'h0, be: 4'hF, rd: 1'b1, wr: 1'b0};
        step();
        step();
        chk("rst_s_read", a_s.read, 1'b0);
        chk("rst_s_address", a_s.address, 32'h0);
        chk("rst_m0_waitrequest", a_m0.waitrequest, 1'b1);
        chk("rst_m1_waitrequest", a_m1.waitrequest, 1'b1);
        chk("rst_m0_readdata", a_m0.readdata, 32'h0);
        reset_n = 1'b1;
        wait_done(0, 20, "rst_release_read_done");
        mcmd[0] = '0;

        // Single write, zero-wait slave.
        mcmd[0] = '{addr: 32'h10, wdata: 32'hA5A5A5A5, be: 4'hF, rd: 1'b0, wr: 1'b1};
        done[0] = 1'b0;
        wr_cnt = 0;
        wr_seen = '0;
        for (int k = 0; k < 20 && !done[0]; k++) begin
            step();
            if (obs_a.s.wr) begin wr_cnt++; wr_seen = obs_a.s; end
        end
        mcmd[0] = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (obs_a.s.wr) wr_cnt++;
        end
        chk("wr_pulse_count", wr_cnt, 1);
        chk("wr_address", wr_seen.addr, 32'h10);
        chk("wr_writedata", wr_seen.wdata, 32'hA5A5A5A5);
        chk("wr_byteenable", wr_seen.be, 4'hF);

        // Slave stalls five granted cycles on an m1 read.
        idle(3);
        mcmd[1] = '{addr: 32'h200, wdata: 32'h0, be: 4'hF, rd: 1'b1, wr: 1'b0};
        s_rdata = 32'h12345678;
        s_wait = 1'b1;
        for (int k = 0; k < 6; k++) step();
        chk("stall_still_pending", done[1], 1'b0);
        s_wait = 1'b0;
        step();
        chk("stall_done", done[1], 1'b1);
        chk("stall_m1_readdata", obs_a.rdata1, 32'h12345678);
        chk("stall_no_timeout", obs_a.terr, 1'b0);
        chk("stall_b_m1_readdata", obs_b.rdata1, 32'h12345678);
        idle(3);

        // Continuous contention, zero-wait slave.
        prev_a = -1; last0_a = -1; last0_b = -1; m1_b = 0;
        for (int k = 0; k < 60; k++) begin
            drive_masters(100, 100, 0);
            step();
            if (comp_a >= 0) begin
                if (prev_a >= 0) chk("rr_alternate", comp_a, 1 - prev_a);
                prev_a = comp_a;
                if (comp_a == 0) begin
                    if (last0_a >= 0) chk("rr_m0_period", cyc - last0_a, 6);
                    last0_a = cyc;
                end
            end
            if (comp_b == 0) begin
                if (last0_b >= 0) chk("fp_m0_period", cyc - last0_b, 3);
                last0_b = cyc;
            end
            if (comp_b == 1) m1_b++;
        end
        chk("fp_m1_starved", m1_b, 0);
        m1_b = 0;
        for (int k = 0; k < 15; k++) begin
            drive_masters(0, 100, 0);
            step();
            if (comp_b == 1) m1_b++;
        end
        chk("fp_m1_served_when_m0_idle", m1_b > 0, 1'b1);

        // Random traffic with a stalling slave.
        for (int k = 0; k < 600; k++) begin
            drive_masters(50, 50, 30);
            step();
        end
        idle(4);

        // Watchdog: slave stuck in waitrequest.
        mcmd[0] = '{addr: 32'h80, wdata: 32'h0, be: 4'hF, rd: 1'b1, wr: 1'b0};
        s_wait = 1'b1;
        s_rdata = 32'hCAFEF00D;
        gcnt = 0;
        for (int k = 0; k < 30 && !obs_a.terr; k++) begin
            step();
            if (obs_a.s.rd) gcnt++;
        end
        chk("wd_fired", obs_a.terr, 1'b1);
        chk("wd_granted_cycles", gcnt, 9);
        chk("wd_m0_waitrequest", obs_a.wait0, 1'b0);
        chk("wd_m0_readdata", obs_a.rdata0, 32'h0);
        step();
        chk("wd_s_read_dropped", obs_a.s.rd, 1'b0);
        chk("wd_pulse_one_cycle", obs_a.terr, 1'b0);
        chk("wd_off_no_timeout", obs_b.terr, 1'b0);
        chk("wd_off_still_stalled", obs_b.wait0, 1'b1);
        for (int k = 0; k < 4; k++) step();
        chk("pre_reset_granted", obs_a.s.rd, 1'b1);

        // Asynchronous reset in the middle of the stall.
        #2;
        reset_n = 1'b0;
        st_a = rst_state();
        st_b = rst_state();
        #1;
        chk("arst_a_s_read", a_s.read, 1'b0);
        chk("arst_a_s_address", a_s.address, 32'h0);
        chk("arst_b_s_read", b_s.read, 1'b0);
        chk("arst_a_m0_waitrequest", a_m0.waitrequest, 1'b1);
        step();
        reset_n = 1'b1;
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "global timeout");
    end
endmodule
